// File: rtl/memory_read_responder_pkg.sv
// Shared types and constants for the AXI4 read-channel memory responder:
// bus widths, request-queue entry layout, FSM states and response codes.
package memory_read_responder_pkg;

    localparam int MEMORY_AXI4_READ_ID_WIDTH = 2;
    localparam int MEMORY_AXI4_READ_ID_NUM   = 1 << MEMORY_AXI4_READ_ID_WIDTH;
    localparam int MEMORY_AXI4_ADDR_BIT_SIZE = 32;
    localparam int MEMORY_AXI4_DATA_BIT_NUM  = 32;
    localparam int MEMORY_AXI4_LEN_WIDTH     = 8;
    localparam int MEMORY_AXI4_BEAT_BYTES    = MEMORY_AXI4_DATA_BIT_NUM / 8;
    localparam int MEMORY_AXI4_BEAT_SHIFT    = $clog2(MEMORY_AXI4_BEAT_BYTES);

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [MEMORY_AXI4_READ_ID_WIDTH-1:0] id;
        logic [MEMORY_AXI4_ADDR_BIT_SIZE-1:0] addr;
        logic [MEMORY_AXI4_LEN_WIDTH-1:0]     len;
    } MemoryReadRespEntry;

    typedef enum logic [1:0] {
        STATE_IDLE = 2'd0,
        STATE_READ = 2'd1,
        STATE_SEND = 2'd2
    } MemoryReadResponderState;

    // INCR bursts only; the sum wraps naturally at the address width.
    function automatic logic [MEMORY_AXI4_ADDR_BIT_SIZE-1:0] nextBeatAddr(
        input logic [MEMORY_AXI4_ADDR_BIT_SIZE-1:0] addr
    );
        return addr + MEMORY_AXI4_ADDR_BIT_SIZE'(MEMORY_AXI4_BEAT_BYTES);
    endfunction

endpackage

// File: rtl/memory_read_responder_queue_pointer.sv
// Head/tail/occupancy bookkeeping for a circular queue of SIZE entries.
// Pushes into a full queue and pops from an empty one are ignored.
module QueuePointer #(
    parameter  int SIZE  = 4,
    localparam int PTR_W = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    output logic [PTR_W-1:0] o_head,
    output logic [PTR_W-1:0] o_tail,
    output logic             o_full,
    output logic             o_empty
);

    localparam int               CNT_W    = $clog2(SIZE + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(SIZE - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SIZE);

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign w_doPush = i_push && (r_count != FULL_CNT);
    assign w_doPop  = i_pop && (r_count != '0);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_tail <= (r_tail == LAST_PTR) ? '0 : r_tail + 1'b1;
            end
            if (w_doPop) begin
                r_head <= (r_head == LAST_PTR) ? '0 : r_head + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_head;
    assign o_tail  = r_tail;
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/memory_read_responder.sv
// AXI4 read-channel responder: queues AR requests in order and returns INCR bursts from a sync memory.
// Optional MEMORY_READ_RESPONDER_RANGE_CHECK_EN: beats beyond the memory return SLVERR with zero data.
module memory_read_responder
    import memory_read_responder_pkg::*;
#(
    parameter int MEM_INDEX_WIDTH = 16
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_arvalid,
    output logic                                  o_arready,
    input  logic [MEMORY_AXI4_READ_ID_WIDTH-1:0]  i_arid,
    input  logic [MEMORY_AXI4_ADDR_BIT_SIZE-1:0]  i_araddr,
    input  logic [MEMORY_AXI4_LEN_WIDTH-1:0]      i_arlen,
    output logic                                  o_rvalid,
    input  logic                                  i_rready,
    output logic [MEMORY_AXI4_READ_ID_WIDTH-1:0]  o_rid,
    output logic [MEMORY_AXI4_DATA_BIT_NUM-1:0]   o_rdata,
    output logic [1:0]                            o_rresp,
    output logic                                  o_rlast,
    output logic                                  o_memRe,
    output logic [MEM_INDEX_WIDTH-1:0]            o_memIndex,
    input  logic [MEMORY_AXI4_DATA_BIT_NUM-1:0]   i_memRData
);

    localparam int QUEUE_PTR_W = (MEMORY_AXI4_READ_ID_NUM > 1) ? $clog2(MEMORY_AXI4_READ_ID_NUM) : 1;

    MemoryReadResponderState r_state;
    MemoryReadResponderState w_nextState;
    MemoryReadRespEntry      r_queue [MEMORY_AXI4_READ_ID_NUM];

    logic [QUEUE_PTR_W-1:0]               w_head;
    logic [QUEUE_PTR_W-1:0]               w_tail;
    logic                                 w_full;
    logic                                 w_empty;
    logic                                 w_push;
    logic                                 w_pop;
    logic                                 w_memRe;
    logic                                 w_lastBeat;
    logic                                 w_beatError;

    logic [MEMORY_AXI4_READ_ID_WIDTH-1:0] r_id;
    logic [MEMORY_AXI4_ADDR_BIT_SIZE-1:0] r_addr;
    logic [MEMORY_AXI4_LEN_WIDTH-1:0]     r_beatCount;
    logic [MEMORY_AXI4_DATA_BIT_NUM-1:0]  r_rdata;
    logic [1:0]                           r_rresp;
    logic                                 r_fresh;

    assign o_arready  = !w_full;
    assign w_push     = i_arvalid && !w_full;
    assign w_lastBeat = (r_beatCount == '0);

`ifdef MEMORY_READ_RESPONDER_RANGE_CHECK_EN
    assign w_beatError = (r_addr >> (MEMORY_AXI4_BEAT_SHIFT + MEM_INDEX_WIDTH)) != '0;
`else
    assign w_beatError = 1'b0;
`endif

    QueuePointer #(
        .SIZE (MEMORY_AXI4_READ_ID_NUM)
    ) u_queuePointer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_tail  (w_tail),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_queue[w_tail].id   <= i_arid;
            r_queue[w_tail].addr <= i_araddr;
            r_queue[w_tail].len  <= i_arlen;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= STATE_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_pop       = 1'b0;
        w_memRe     = 1'b0;
        case (r_state)
            STATE_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_nextState = STATE_READ;
                end
            end
            STATE_READ: begin
                w_memRe     = !w_beatError;
                w_nextState = STATE_SEND;
            end
            STATE_SEND: begin
                if (i_rready) begin
                    w_nextState = w_lastBeat ? STATE_IDLE : STATE_READ;
                end
            end
            default: w_nextState = STATE_IDLE;
        endcase
    end

    // Memory data is only valid in the first SEND cycle, so it is passed through
    // then (r_fresh) and latched so the beat stays stable through a stall.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_id        <= '0;
            r_addr      <= '0;
            r_beatCount <= '0;
            r_rdata     <= '0;
            r_rresp     <= AXI_RESP_OKAY;
            r_fresh     <= 1'b0;
        end else begin
            case (r_state)
                STATE_IDLE: begin
                    if (w_pop) begin
                        r_id        <= r_queue[w_head].id;
                        r_addr      <= r_queue[w_head].addr;
                        r_beatCount <= r_queue[w_head].len;
                    end
                end
                STATE_READ: begin
                    r_rresp <= w_beatError ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                    r_fresh <= !w_beatError;
                    if (w_beatError) begin
                        r_rdata <= '0;
                    end
                end
                STATE_SEND: begin
                    if (r_fresh) begin
                        r_rdata <= i_memRData;
                        r_fresh <= 1'b0;
                    end
                    if (i_rready && !w_lastBeat) begin
                        r_addr      <= nextBeatAddr(r_addr);
                        r_beatCount <= r_beatCount - 1'b1;
                    end
                end
                default: begin
                    r_fresh <= 1'b0;
                end
            endcase
        end
    end

    assign o_rvalid   = (r_state == STATE_SEND);
    assign o_rlast    = o_rvalid && w_lastBeat;
    assign o_rid      = r_id;
    assign o_rresp    = r_rresp;
    assign o_rdata    = r_fresh ? i_memRData : r_rdata;
    assign o_memRe    = w_memRe;
    assign o_memIndex = MEM_INDEX_WIDTH'(r_addr >> MEMORY_AXI4_BEAT_SHIFT);

endmodule

// File: tb/tb_memory_read_responder.sv
// Self-checking bench for memory_read_responder: randomized AR traffic against an in-order
// queue-of-beats reference model, plus directed latency, stall, full-queue and reset scenarios.
module tb_memory_read_responder;
    import memory_read_responder_pkg::*;

    localparam int          IDX_W     = 16;
    localparam int          IDW       = MEMORY_AXI4_READ_ID_WIDTH;
    localparam int          MEM_WORDS = 1 << IDX_W;
    localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

    typedef struct {
        logic [IDW-1:0] id;
        logic [31:0]    data;
        logic [1:0]     resp;
        logic           last;
    } ExpectedBeat;

    logic             clk = 1'b0;
    logic             rst;
    logic             arvalid;
    logic             arready;
    logic [IDW-1:0]   arid;
    logic [31:0]      araddr;
    logic [7:0]       arlen;
    logic             rvalid;
    logic             rready;
    logic [IDW-1:0]   rid;
    logic [31:0]      rdata;
    logic [1:0]       rresp;
    logic             rlast;
    logic             memRe;
    logic [IDX_W-1:0] memIndex;
    logic [31:0]      memRData;

    logic [31:0]      mem [MEM_WORDS];
    ExpectedBeat      expQ [$];
    int               testsRun    = 0;
    int               testsFailed = 0;

    always #5 clk = ~clk;

    // Synchronous memory: data valid only the cycle after a read enable, garbage otherwise.
    always @(posedge clk) memRData <= memRe ? mem[memIndex] : $urandom;

    memory_read_responder #(
        .MEM_INDEX_WIDTH (IDX_W)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_arvalid  (arvalid),
        .o_arready  (arready),
        .i_arid     (arid),
        .i_araddr   (araddr),
        .i_arlen    (arlen),
        .o_rvalid   (rvalid),
        .i_rready   (rready),
        .o_rid      (rid),
        .o_rdata    (rdata),
        .o_rresp    (rresp),
        .o_rlast    (rlast),
        .o_memRe    (memRe),
        .o_memIndex (memIndex),
        .i_memRData (memRData)
    );

    // Reference model: every accepted request expands into its list of expected beats.
    function automatic void modelRequest(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len);
        ExpectedBeat b;
        logic [31:0] a;
        for (int k = 0; k <= int'(len); k++) begin
            a      = addr + 32'(4 * k);
            b.id   = id;
            b.last = (k == int'(len));
            b.data = mem[IDX_W'(a / 4)];
            b.resp = 2'd0;
`ifdef MEMORY_READ_RESPONDER_RANGE_CHECK_EN
            if (a >= MEM_BYTES) begin
                b.data = 32'd0;
                b.resp = 2'd2;
            end
`endif
            expQ.push_back(b);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; arvalid = 1'b0; rready = 1'b0;
        tick(); tick();
        testsRun++; if (arready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_arready: got %0b expected 1", arready); end
        testsRun++; if (rvalid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_rvalid: got %0b expected 0", rvalid); end
        testsRun++; if (rlast !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_rlast: got %0b expected 0", rlast); end
        testsRun++; if (rresp !== 2'd0) begin testsFailed++; $display("[TB] FAIL reset_rresp: got %0d expected 0", rresp); end
        testsRun++; if (rid !== '0) begin testsFailed++; $display("[TB] FAIL reset_rid: got %0d expected 0", rid); end
        testsRun++; if (rdata !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata); end
        testsRun++; if (memRe !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_memRe: got %0b expected 0", memRe); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_beat();
        mem[IDX_W'(16)] = 32'hDEADBEEF;
        arvalid = 1'b1; arid = IDW'(3); araddr = 32'h40; arlen = 8'd0; rready = 1'b1;
        testsRun++; if (arready !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_arready: got %0b expected 1", arready); end
        tick();
        arvalid = 1'b0;
        testsRun++; if (rvalid !== 1'b0 || memRe !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_t1: got rvalid=%0b memRe=%0b expected 0/0", rvalid, memRe); end
        tick();
        testsRun++; if (rvalid !== 1'b0 || memRe !== 1'b1 || memIndex !== IDX_W'(16)) begin
            testsFailed++; $display("[TB] FAIL single_t2: got rvalid=%0b memRe=%0b index=%0d expected 0/1/16", rvalid, memRe, memIndex); end
        tick();
        testsRun++; if (rvalid !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_t3_rvalid: got %0b expected 1", rvalid); end
        testsRun++; if ({rid, rdata, rresp, rlast} !== {IDW'(3), 32'hDEADBEEF, 2'd0, 1'b1}) begin
            testsFailed++; $display("[TB] FAIL single_beat: got id=%0d data=%h resp=%0d last=%0b expected id=3 data=deadbeef resp=0 last=1", rid, rdata, rresp, rlast); end
        tick();
        testsRun++; if (rvalid !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_after: got rvalid=%0b expected 0", rvalid); end
    endtask

    task automatic test_burst4();
        logic [IDW-1:0] id;
        int seen;
        int lastCyc;
        id = IDW'($urandom);
        arvalid = 1'b1; arid = id; araddr = 32'h20; arlen = 8'd3; rready = 1'b1;
        testsRun++; if (arready !== 1'b1) begin testsFailed++; $display("[TB] FAIL burst4_arready: got %0b expected 1", arready); end
        tick();
        arvalid = 1'b0;
        seen = 0; lastCyc = 0;
        for (int c = 0; c < 30; c++) begin
            if (rvalid) begin
                testsRun++;
                if (seen >= 4) begin
                    testsFailed++; $display("[TB] FAIL burst4_extra: got beat %0d expected 4 beats only", seen + 1);
                end else if ({rid, rdata, rlast} !== {id, mem[IDX_W'(8 + seen)], seen == 3}) begin
                    testsFailed++; $display("[TB] FAIL burst4_beat%0d: got id=%0d data=%h last=%0b expected id=%0d data=%h last=%0b",
                        seen, rid, rdata, rlast, id, mem[IDX_W'(8 + seen)], seen == 3);
                end
                testsRun++;
                if (seen == 0 && c != 2) begin
                    testsFailed++; $display("[TB] FAIL burst4_latency: got cycle %0d expected 2", c);
                end else if (seen > 0 && c - lastCyc != 2) begin
                    testsFailed++; $display("[TB] FAIL burst4_spacing: got %0d cycles expected 2", c - lastCyc);
                end
                lastCyc = c;
                seen++;
            end
            tick();
        end
        testsRun++; if (seen != 4) begin testsFailed++; $display("[TB] FAIL burst4_count: got %0d beats expected 4", seen); end
    endtask

    task automatic test_queue_full();
        ExpectedBeat e;
        int accepts;
        int lastHs;
        bit firstDone;
        expQ.delete();
        rready = 1'b0; accepts = 0;
        for (int c = 0; c < 12; c++) begin
            arvalid = 1'b1; arid = IDW'($urandom);
            araddr = 32'($urandom_range(0, 4095)) * 4; arlen = 8'($urandom_range(0, 3));
            if (arready) begin modelRequest(arid, araddr, arlen); accepts++; end
            tick();
        end
        arvalid = 1'b0;
        testsRun++; if (accepts != MEMORY_AXI4_READ_ID_NUM + 1) begin
            testsFailed++; $display("[TB] FAIL full_accepts: got %0d expected %0d", accepts, MEMORY_AXI4_READ_ID_NUM + 1); end
        testsRun++; if (arready !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_arready_low: got %0b expected 0", arready); end
        rready = 1'b1; firstDone = 1'b0; lastHs = -10;
        for (int c = 0; c < 400; c++) begin
            if (c == lastHs + 1) begin
                testsRun++; if (arready !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_arready_pop: got %0b expected 0", arready); end
            end
            if (c == lastHs + 2) begin
                testsRun++; if (arready !== 1'b1) begin testsFailed++; $display("[TB] FAIL full_arready_rise: got %0b expected 1", arready); end
            end
            if (rvalid) begin
                testsRun++;
                if (expQ.size() == 0) begin
                    testsFailed++; $display("[TB] FAIL full_unexpected: got id=%0d data=%h expected no beat", rid, rdata);
                end else begin
                    e = expQ.pop_front();
                    if ({rid, rdata, rresp, rlast} !== {e.id, e.data, e.resp, e.last}) begin
                        testsFailed++; $display("[TB] FAIL full_order: got id=%0d data=%h resp=%0d last=%0b expected id=%0d data=%h resp=%0d last=%0b",
                            rid, rdata, rresp, rlast, e.id, e.data, e.resp, e.last);
                    end
                    if (e.last && !firstDone) begin firstDone = 1'b1; lastHs = c; end
                end
            end
            if (firstDone && c > lastHs + 2 && expQ.size() == 0 && !rvalid) break;
            tick();
        end
        testsRun++; if (expQ.size() != 0) begin testsFailed++; $display("[TB] FAIL full_drain: got %0d beats left expected 0", expQ.size()); end
    endtask

    task automatic test_stall();
        ExpectedBeat e;
        logic [IDW-1:0] prevRid;
        logic [31:0]    prevData;
        logic           prevLast;
        bit             prevStall;
        int             beats;
        expQ.delete();
        arvalid = 1'b1; arid = IDW'($urandom);
        araddr = 32'($urandom_range(0, MEM_WORDS - 8)) * 4; arlen = 8'd7; rready = 1'b0;
        testsRun++; if (arready !== 1'b1) begin testsFailed++; $display("[TB] FAIL stall_arready: got %0b expected 1", arready); end
        modelRequest(arid, araddr, arlen);
        tick();
        arvalid = 1'b0;
        prevStall = 1'b0; beats = 0; prevRid = '0; prevData = '0; prevLast = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (prevStall) begin
                testsRun++;
                if ({rvalid, rid, rdata, rlast} !== {1'b1, prevRid, prevData, prevLast}) begin
                    testsFailed++; $display("[TB] FAIL stall_hold: got valid=%0b id=%0d data=%h last=%0b expected valid=1 id=%0d data=%h last=%0b",
                        rvalid, rid, rdata, rlast, prevRid, prevData, prevLast);
                end
            end
            rready = ($urandom_range(0, 1) == 1);
            prevStall = rvalid && !rready;
            prevRid = rid; prevData = rdata; prevLast = rlast;
            if (rvalid && rready) begin
                testsRun++;
                if (expQ.size() == 0) begin
                    testsFailed++; $display("[TB] FAIL stall_extra: got id=%0d data=%h expected no beat", rid, rdata);
                end else begin
                    e = expQ.pop_front();
                    if ({rid, rdata, rresp, rlast} !== {e.id, e.data, e.resp, e.last}) begin
                        testsFailed++; $display("[TB] FAIL stall_beat%0d: got id=%0d data=%h resp=%0d last=%0b expected id=%0d data=%h resp=%0d last=%0b",
                            beats, rid, rdata, rresp, rlast, e.id, e.data, e.resp, e.last);
                    end
                end
                beats++;
            end
            if (beats >= 8 && !rvalid) break;
            tick();
        end
        rready = 1'b0;
        testsRun++; if (beats != 8 || expQ.size() != 0) begin
            testsFailed++; $display("[TB] FAIL stall_count: got %0d beats (%0d left) expected 8 (0 left)", beats, expQ.size()); end
    endtask

    task automatic test_reset_mid_burst();
        int beat;
        int extra;
        bit resetDone;
        expQ.delete();
        rready = 1'b0;
        for (int r = 0; r < 3; r++) begin
            arvalid = 1'b1; arid = IDW'($urandom);
            araddr = 32'($urandom_range(0, 4095)) * 4; arlen = (r == 0) ? 8'd3 : 8'd1;
            testsRun++; if (arready !== 1'b1) begin testsFailed++; $display("[TB] FAIL midrst_arready%0d: got %0b expected 1", r, arready); end
            tick();
        end
        arvalid = 1'b0; rready = 1'b1; beat = 0; resetDone = 1'b0;
        for (int c = 0; c < 40 && !resetDone; c++) begin
            if (rvalid) begin
                if (beat == 1) begin rst = 1'b0; rready = 1'b0; resetDone = 1'b1; end
                beat++;
            end
            tick();
        end
        testsRun++; if (!resetDone) begin testsFailed++; $display("[TB] FAIL midrst_reach: got %0d beats expected to reach beat 2", beat); end
        testsRun++; if ({rvalid, arready, rlast, memRe} !== 4'b0100) begin
            testsFailed++; $display("[TB] FAIL midrst_state: got rvalid=%0b arready=%0b rlast=%0b memRe=%0b expected 0/1/0/0", rvalid, arready, rlast, memRe); end
        rst = 1'b1; rready = 1'b1; extra = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (rvalid) extra++;
        end
        testsRun++; if (extra != 0) begin testsFailed++; $display("[TB] FAIL midrst_leftover: got %0d beats expected 0", extra); end
    endtask

    task automatic test_range();
        ExpectedBeat e;
        int memReCount;
        int expMemRe;
        rready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            expQ.delete();
            arvalid = 1'b1; arid = IDW'($urandom); arlen = 8'd1;
            if (r == 0) araddr = (32'($urandom_range(1, 255)) << 18) | (32'($urandom_range(0, 65534)) << 2);
            else        araddr = MEM_BYTES - 32'd4;
`ifdef MEMORY_READ_RESPONDER_RANGE_CHECK_EN
            expMemRe = (r == 0) ? 0 : 1;
`else
            expMemRe = 2;
`endif
            testsRun++; if (arready !== 1'b1) begin testsFailed++; $display("[TB] FAIL range%0d_arready: got %0b expected 1", r, arready); end
            modelRequest(arid, araddr, arlen);
            tick();
            arvalid = 1'b0; memReCount = 0;
            for (int c = 0; c < 40; c++) begin
                if (memRe) memReCount++;
                if (rvalid) begin
                    testsRun++;
                    if (expQ.size() == 0) begin
                        testsFailed++; $display("[TB] FAIL range%0d_extra: got id=%0d data=%h expected no beat", r, rid, rdata);
                    end else begin
                        e = expQ.pop_front();
                        if ({rid, rdata, rresp, rlast} !== {e.id, e.data, e.resp, e.last}) begin
                            testsFailed++; $display("[TB] FAIL range%0d_beat: got id=%0d data=%h resp=%0d last=%0b expected id=%0d data=%h resp=%0d last=%0b",
                                r, rid, rdata, rresp, rlast, e.id, e.data, e.resp, e.last);
                        end
                    end
                end
                if (expQ.size() == 0 && !rvalid) break;
                tick();
            end
            testsRun++; if (expQ.size() != 0) begin testsFailed++; $display("[TB] FAIL range%0d_drain: got %0d beats left expected 0", r, expQ.size()); end
            testsRun++; if (memReCount != expMemRe) begin testsFailed++; $display("[TB] FAIL range%0d_memRe: got %0d reads expected %0d", r, memReCount, expMemRe); end
        end
    endtask

    task automatic test_random();
        ExpectedBeat e;
        int issued;
        bit accepted;
        expQ.delete();
        issued = 0; accepted = 1'b0; arvalid = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (accepted) begin arvalid = 1'b0; accepted = 1'b0; end
            if (!arvalid && issued < 8 && $urandom_range(0, 2) == 0) begin
                arvalid = 1'b1; arid = IDW'($urandom); arlen = 8'($urandom_range(0, 7));
                araddr = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : 32'($urandom_range(0, MEM_WORDS - 1)) * 4;
            end
            if (arvalid && arready) begin modelRequest(arid, araddr, arlen); issued++; accepted = 1'b1; end
            rready = ($urandom_range(0, 3) != 0);
            if (rvalid && rready) begin
                testsRun++;
                if (expQ.size() == 0) begin
                    testsFailed++; $display("[TB] FAIL random_extra: got id=%0d data=%h expected no beat", rid, rdata);
                end else begin
                    e = expQ.pop_front();
                    if ({rid, rdata, rresp, rlast} !== {e.id, e.data, e.resp, e.last}) begin
                        testsFailed++; $display("[TB] FAIL random_beat: got id=%0d data=%h resp=%0d last=%0b expected id=%0d data=%h resp=%0d last=%0b",
                            rid, rdata, rresp, rlast, e.id, e.data, e.resp, e.last);
                    end
                end
            end
            if (issued == 8 && !arvalid && expQ.size() == 0 && !rvalid) break;
            tick();
        end
        arvalid = 1'b0;
        testsRun++; if (issued != 8 || expQ.size() != 0) begin
            testsFailed++; $display("[TB] FAIL random_done: got %0d issued %0d left expected 8 issued 0 left", issued, expQ.size()); end
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[IDX_W'(i)] = $urandom;
        rst = 1'b0; arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0; rready = 1'b0;
        test_reset();
        test_single_beat();
        test_burst4();
        test_queue_full();
        test_stall();
        test_reset_mid_burst();
        test_range();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
